alu_flag_stage: RTL

Registered output stage placed directly downstream of the 32-bit signed add/subtract datapath. It accepts the combinational result and its four status flags (overflow, carry, zero, negative) through a valid/ready handshake. It buffers them in a two-entry skid buffer and presents them registered to the writeback/branch logic. It also keeps a sticky overflow flag and a saturating overflow-event counter for software inspection.

---
 rtl/alu_flag_stage.sv | 67 ++++++
 1 files changed

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: two-entry skid-buffered flag/result register with sticky overflow and saturating event counter.
// Define SATURATE_EN to clamp overflowed results to the signed limits before buffering.
module alu_flag_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_of,
    input  logic             in_cf,
    input  logic             in_zf,
    input  logic             in_nf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_of,
    output logic             out_cf,
    output logic             out_zf,
    output logic             out_nf,
    input  logic             clr_sticky,
    output logic             sticky_of,
    output logic [CNT_W-1:0] ovf_count
);
    logic [35:0] in_e, out_e, skid_e;
    logic        skid_v, acc, dlv, ovf_acc;
`ifdef SATURATE_EN
    // wrapped negative means the true result was positive, so clamp to the opposite limit
    assign in_e = in_of ? {in_nf ? 32'h7fffffff : 32'h80000000, 1'b1, in_cf, 1'b0, ~in_nf}
                        : {in_result, in_of, in_cf, in_zf, in_nf};
`else
    assign in_e = {in_result, in_of, in_cf, in_zf, in_nf};
`endif
    assign in_ready = !skid_v;
    assign acc      = in_valid && in_ready;
    assign dlv      = out_valid && out_ready;
    assign ovf_acc  = acc && in_e[3];
    assign {out_result, out_of, out_cf, out_zf, out_nf} = out_e;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            skid_v    <= 1'b0;
            out_e     <= '0;
            skid_e    <= '0;
            sticky_of <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (!out_valid || dlv) begin
                out_valid <= skid_v || acc;
                skid_v    <= 1'b0;
                if (skid_v)
                    out_e <= skid_e;
                else if (acc)
                    out_e <= in_e;
            end else if (acc) begin
                skid_e <= in_e;
                skid_v <= 1'b1;
            end
            sticky_of <= ovf_acc || (sticky_of && !clr_sticky);
            if (clr_sticky)
                ovf_count <= ovf_acc ? CNT_W'(1) : '0;
            else if (ovf_acc && ovf_count != '1)
                ovf_count <= ovf_count + CNT_W'(1);
        end
    end
endmodule
